// File: rtl/digit_serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter width: ceil(log2(n)), never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry slice; exposes the carry into the top bit for overflow.
module digit_adder #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  // Bitwise ripple through the slice.
  always_comb begin
    logic [DIGIT:0] v_c;
    v_c    = '0;
    sum    = '0;
    v_c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = x[i] ^ y[i] ^ v_c[i];
      v_c[i+1] = (x[i] & y[i]) | (x[i] & v_c[i]) | (y[i] & v_c[i]);
    end
    cout  = v_c[DIGIT];
    c_msb = v_c[DIGIT-1];
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Iterative add/subtract: DIGIT bits per clock with a registered carry between digits.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = cnt_width(N);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_carry;
  logic [WIDTH-1:0] r_res_sh;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_ovf;

  logic [DIGIT-1:0] w_sum;
  logic             w_cout;
  logic             w_c_msb;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .x     (r_a_sh[DIGIT-1:0]),
    .y     (r_b_sh[DIGIT-1:0]),
    .cin   (r_carry),
    .sum   (w_sum),
    .cout  (w_cout),
    .c_msb (w_c_msb)
  );

  // New sum digit enters at the top so the first digit ends at bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign w_res_next = w_sum;
    end else begin : g_multi
      assign w_res_next = {w_sum, r_res_sh[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign w_last = (r_cnt == CW'(N - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, digit iteration and final result load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_carry  <= 1'b0;
      r_res_sh <= '0;
      r_cnt    <= '0;
      r_s      <= '0;
      r_co     <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_a_sh  <= a;
        r_b_sh  <= b ^ {WIDTH{sub}};
        r_carry <= sub | ci;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_a_sh   <= r_a_sh >> DIGIT;
        r_b_sh   <= r_b_sh >> DIGIT;
        r_carry  <= w_cout;
        r_res_sh <= w_res_next;
        r_cnt    <= r_cnt + CW'(1);
        if (w_last) begin
          r_s   <= w_res_next;
          r_co  <= w_cout;
          r_ovf <= w_c_msb ^ w_cout;
        end
      end
    end
  end

  assign s   = r_s;
  assign co  = r_co;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed and random checks of digit_serial_adder at WIDTH=8 for DIGIT = 1, 2, 4, 8.
module tb_digit_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sub;
  logic       ci;
  logic [7:0] a;
  logic [7:0] b;

  logic       busy_o [4];
  logic       done_o [4];
  logic       co_o   [4];
  logic       ovf_o  [4];
  logic [7:0] s_o    [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
    .busy(busy_o[0]), .done(done_o[0]), .s(s_o[0]), .co(co_o[0]), .ovf(ovf_o[0]));
  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
    .busy(busy_o[1]), .done(done_o[1]), .s(s_o[1]), .co(co_o[1]), .ovf(ovf_o[1]));
  digit_serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
    .busy(busy_o[2]), .done(done_o[2]), .s(s_o[2]), .co(co_o[2]), .ovf(ovf_o[2]));
  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
    .busy(busy_o[3]), .done(done_o[3]), .s(s_o[3]), .co(co_o[3]), .ovf(ovf_o[3]));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       sub;
    logic [7:0] exp_s;
    logic       exp_co;
    logic       exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain 9-bit sum of a, (possibly inverted) b and carry-in; returns {ovf, co, s}.
  function automatic logic [9:0] model(input logic [7:0] aa, input logic [7:0] bb,
                                       input logic cc, input logic ss);
    logic [7:0] bx;
    logic       c0;
    logic [8:0] t;
    logic       v;
    bx = ss ? ~bb : bb;
    c0 = ss ? 1'b1 : cc;
    t  = {1'b0, aa} + {1'b0, bx} + {8'd0, c0};
    v  = (aa[7] == bx[7]) && (t[7] != aa[7]);
    return {v, t[8], t[7:0]};
  endfunction

  // One operation on all four instances; mode 1 disturbs inputs and re-pulses start mid-run.
  task automatic run_op(input logic [7:0] aa, input logic [7:0] bb, input logic cc,
                        input logic ss, input logic [9:0] exp, input int mode, input string tag);
    int         busy_cnt  [4];
    int         done_cnt  [4];
    int         done_edge [4];
    int         early     [4];
    logic [9:0] prev      [4];
    int         n;
    @(negedge clk);
    a = aa; b = bb; ci = cc; sub = ss; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      busy_cnt[i] = 0; done_cnt[i] = 0; done_edge[i] = -1; early[i] = 0;
      prev[i] = {ovf_o[i], co_o[i], s_o[i]};
    end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k == 0) start = 1'b0;
      if (mode == 1 && k == 1) begin
        a = ~aa; b = 8'h11; ci = ~cc; sub = ~ss; start = 1'b1;
      end
      if (mode == 1 && k == 2) start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        n = 8 >> i;
        if (busy_o[i]) busy_cnt[i]++;
        if (done_o[i]) begin
          done_cnt[i]++;
          if (done_edge[i] < 0) done_edge[i] = k;
        end
        if (k < n && {ovf_o[i], co_o[i], s_o[i]} != prev[i]) early[i]++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      n = 8 >> i;
      chk($sformatf("%s/D%0d result", tag, 1 << i), 32'({ovf_o[i], co_o[i], s_o[i]}), 32'(exp));
      chk($sformatf("%s/D%0d done_edge", tag, 1 << i), 32'(done_edge[i]), 32'(n));
      chk($sformatf("%s/D%0d done_pulses", tag, 1 << i), 32'(done_cnt[i]), 32'd1);
      chk($sformatf("%s/D%0d busy_cycles", tag, 1 << i), 32'(busy_cnt[i]), 32'(n));
      chk($sformatf("%s/D%0d early_change", tag, 1 << i), 32'(early[i]), 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s/D%0d outs", tag, 1 << i),
          32'({busy_o[i], done_o[i], ovf_o[i], co_o[i], s_o[i]}), 32'd0);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'h05, 8'h05, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst = 1'b0;

    for (int v = 0; v < 8; v++)
      run_op(vecs[v].a, vecs[v].b, vecs[v].ci, vecs[v].sub,
             {vecs[v].exp_ovf, vecs[v].exp_co, vecs[v].exp_s}, 0, $sformatf("vec%0d", v));

    // Restart attempt and operand changes during a run are ignored.
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, {1'b1, 1'b0, 8'h96}, 1, "ignore");

    // Reset mid-run aborts with no done pulse.
    @(negedge clk);
    a = 8'h7F; b = 8'h01; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_all_zero("abort");
    begin
      int dseen;
      dseen = 0;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) if (done_o[i] || busy_o[i]) dseen++;
      end
      @(negedge clk) rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) if (done_o[i] || busy_o[i]) dseen++;
      end
      chk("abort quiet", 32'(dseen), 32'd0);
    end
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80}, 0, "post_reset");

    // Random sweep against the reference model.
    for (int r = 0; r < 1000; r++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      logic       rs;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs), 0, $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
